// File: rtl/sid_voice_mixer_pkg.sv
// sid_voice_mixer_pkg: shared types and constants for the SID voice mixer.
// Holds the mix sequencer state enum, the waveform centre offset and the
// envelope scaling shift.
package sid_voice_mixer_pkg;
    typedef enum logic [2:0] {IDLE, S_V0, S_V1, S_V2, S_EXT, S_OUT} state_t;
    localparam int WAVE_CENTRE = 2048;
    localparam int ENV_SHIFT = 8;
endpackage

// File: rtl/sid_env_scale.sv
// sid_env_scale: centres one unsigned voice waveform around zero and scales it
// by its envelope, term = floor((wave - WAVE_CENTRE) * env / 2^ENV_SHIFT).
// Ports: wave (unsigned waveform), env (unsigned envelope), term (signed result).
module sid_env_scale
    import sid_voice_mixer_pkg::*;
#(
    parameter int WAVE_W = 12,
    parameter int ENV_W = 8
) (
    input  logic [WAVE_W-1:0]        wave,
    input  logic [ENV_W-1:0]         env,
    output logic signed [WAVE_W+1:0] term
);
    localparam int PW = WAVE_W + ENV_W + 1;
    logic [WAVE_W-1:0]   centred;
    logic signed [PW-1:0] prod;
    // Subtracting the centre modulo 2^WAVE_W just flips the MSB, giving a
    // two's-complement value without a real subtractor.
    assign centred = wave - WAVE_W'(WAVE_CENTRE);
    assign prod = PW'($signed(centred)) * PW'($signed({1'b0, env}));
    assign term = (WAVE_W+2)'(prod >>> ENV_SHIFT);
endmodule

// File: rtl/sid_voice_mixer.sv
// sid_voice_mixer: per-sample mixer ahead of the SID filter. Snapshots inputs
// on sample_stb, scales the three voices by their envelopes through one shared
// multiplier, then routes each voice and ext_in to the filter or bypass sum.
// Ports: clk, reset (sync, active-high), sample_stb (start pass),
//   wave0..2 / env0..2 (voice waveforms and envelopes), ext_in (signed audio),
//   filt (routing, 1 = filter), voice3off (mutes voice2 in bypass),
//   busy (pass running), filt_in (signed filter sum / 4), bypass (signed sum),
//   valid (one-cycle update pulse), overrun (sticky strobe-while-busy flag).
module sid_voice_mixer
    import sid_voice_mixer_pkg::*;
#(
    parameter int WAVE_W = 12,
    parameter int ENV_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_stb,
    input  logic [WAVE_W-1:0] wave0,
    input  logic [WAVE_W-1:0] wave1,
    input  logic [WAVE_W-1:0] wave2,
    input  logic [ENV_W-1:0]  env0,
    input  logic [ENV_W-1:0]  env1,
    input  logic [ENV_W-1:0]  env2,
    input  logic [11:0]       ext_in,
    input  logic [3:0]        filt,
    input  logic              voice3off,
    output logic              busy,
    output logic [11:0]       filt_in,
    output logic [13:0]       bypass,
    output logic              valid,
    output logic              overrun
);
    state_t state, state_n;
    logic [WAVE_W-1:0] w0_s, w1_s, w2_s, wave_m;
    logic [ENV_W-1:0] e0_s, e1_s, e2_s, env_m;
    logic [11:0] ext_s;
    logic [3:0] filt_s;
    logic v3off_s;
    logic signed [WAVE_W+1:0] term;
    logic signed [13:0] acc_f, acc_b, add_val;
    logic to_f, acc_en;

    sid_env_scale #(.WAVE_W(WAVE_W), .ENV_W(ENV_W)) u_scale (
        .wave(wave_m),
        .env(env_m),
        .term(term)
    );

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    always_comb begin
        busy = state != IDLE;
        state_n = state;
        case (state)
            IDLE:    state_n = sample_stb ? S_V0 : IDLE;
            S_V0:    state_n = S_V1;
            S_V1:    state_n = S_V2;
            S_V2:    state_n = S_EXT;
            S_EXT:   state_n = S_OUT;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        wave_m = state == S_V1 ? w1_s : state == S_V2 ? w2_s : w0_s;
        env_m = state == S_V1 ? e1_s : state == S_V2 ? e2_s : e0_s;
        add_val = state == S_EXT ? {{2{ext_s[11]}}, ext_s} : 14'(term);
        to_f = state == S_V1 ? filt_s[1] : state == S_V2 ? filt_s[2] :
               state == S_EXT ? filt_s[3] : filt_s[0];
        // voice3off silences voice2 only when it is headed for bypass.
        acc_en = (state inside {S_V0, S_V1, S_V2, S_EXT}) &&
                 !(state == S_V2 && !filt_s[2] && v3off_s);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {w0_s, w1_s, w2_s, e0_s, e1_s, e2_s} <= '0;
            ext_s <= '0;
            filt_s <= '0;
            v3off_s <= 1'b0;
            acc_f <= '0;
            acc_b <= '0;
            filt_in <= '0;
            bypass <= '0;
            valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid <= state == S_OUT;
            if (sample_stb && busy)
                overrun <= 1'b1;
            if (state == IDLE && sample_stb) begin
                {w0_s, w1_s, w2_s} <= {wave0, wave1, wave2};
                {e0_s, e1_s, e2_s} <= {env0, env1, env2};
                ext_s <= ext_in;
                filt_s <= filt;
                v3off_s <= voice3off;
                acc_f <= '0;
                acc_b <= '0;
            end else if (acc_en) begin
                if (to_f)
                    acc_f <= acc_f + add_val;
                else
                    acc_b <= acc_b + add_val;
            end
            if (state == S_OUT) begin
                filt_in <= 12'(acc_f >>> 2);
                bypass <= acc_b;
            end
        end
    end
endmodule

// File: tb/tb_sid_voice_mixer.sv
// tb_sid_voice_mixer: self-checking bench for sid_voice_mixer with a
// sample-level reference model, directed literal cases and random traffic.
module tb_sid_voice_mixer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sample_stb = 1'b0;
    logic [11:0] wave [3] = '{default: 12'd0};
    logic [7:0] env [3] = '{default: 8'd0};
    logic [11:0] ext_in = '0;
    logic [3:0] filt = '0;
    logic voice3off = 1'b0;
    logic busy, valid, overrun;
    logic [11:0] filt_in;
    logic [13:0] bypass;

    int tests = 0;
    int fails = 0;

    int rem = 0, ef = 0, eb = 0, pf = 0, pb = 0;
    logic ev = 1'b0, ebusy = 1'b0, eovr = 1'b0, armed = 1'b0;

    always #5 clk = ~clk;

    sid_voice_mixer dut (
        .clk(clk), .reset(reset), .sample_stb(sample_stb),
        .wave0(wave[0]), .wave1(wave[1]), .wave2(wave[2]),
        .env0(env[0]), .env1(env[1]), .env2(env[2]),
        .ext_in(ext_in), .filt(filt), .voice3off(voice3off),
        .busy(busy), .filt_in(filt_in), .bypass(bypass),
        .valid(valid), .overrun(overrun)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if (a % b != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic void mix(input logic [11:0] w0, w1, w2, input logic [7:0] e0, e1, e2,
                                input logic [11:0] x, input logic [3:0] f, input logic v3,
                                output int of, output int ob);
        int w[3];
        int e[3];
        int sf, sb, t;
        w = '{int'(w0), int'(w1), int'(w2)};
        e = '{int'(e0), int'(e1), int'(e2)};
        sf = 0;
        sb = 0;
        for (int k = 0; k < 3; k++) begin
            t = fdiv((w[k] - 2048) * e[k], 256);
            if (k == 2 && !f[2] && v3) t = 0;
            if (f[k]) sf += t;
            else sb += t;
        end
        if (f[3]) sf += int'($signed(x));
        else sb += int'($signed(x));
        of = fdiv(sf, 4);
        ob = sb;
    endfunction

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("busy", int'(busy), int'(ebusy));
            chk("valid", int'(valid), int'(ev));
            chk("overrun", int'(overrun), int'(eovr));
            chk("filt_in", $signed(filt_in), ef);
            chk("bypass", $signed(bypass), eb);
        end
        if (reset) begin
            rem = 0; ef = 0; eb = 0; ev = 1'b0; eovr = 1'b0; armed = 1'b1;
        end else begin
            ev = rem == 1;
            if (rem == 1) begin
                ef = pf;
                eb = pb;
            end
            if (rem > 0) begin
                if (sample_stb) eovr = 1'b1;
                rem--;
            end else if (sample_stb) begin
                mix(wave[0], wave[1], wave[2], env[0], env[1], env[2],
                    ext_in, filt, voice3off, pf, pb);
                rem = 5;
            end
        end
        ebusy = rem > 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [11:0] w0, w1, w2, input logic [7:0] e0, e1, e2,
                          input logic [11:0] x, input logic [3:0] f, input logic v3);
        wave = '{w0, w1, w2};
        env = '{e0, e1, e2};
        ext_in = x;
        filt = f;
        voice3off = v3;
    endtask

    task automatic do_pass(input string nm, input logic [11:0] w0, w1, w2,
                           input logic [7:0] e0, e1, e2, input logic [11:0] x,
                           input logic [3:0] f, input logic v3, input int xf, input int xb);
        int mf, mb, np;
        mix(w0, w1, w2, e0, e1, e2, x, f, v3, mf, mb);
        chk({nm, "_model_f"}, mf, xf);
        chk({nm, "_model_b"}, mb, xb);
        set_in(w0, w1, w2, e0, e1, e2, x, f, v3);
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        np = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (valid) np++;
            if (i == 5) begin
                chk({nm, "_valid_n5"}, int'(valid), 1);
                chk({nm, "_filt_in"}, $signed(filt_in), xf);
                chk({nm, "_bypass"}, $signed(bypass), xb);
            end
            if (i == 6) chk({nm, "_busy_n6"}, int'(busy), 0);
        end
        chk({nm, "_pulses"}, np, 1);
    endtask

    initial begin
        int np, gap;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_filt_in", $signed(filt_in), 0);
        chk("rst_bypass", $signed(bypass), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);

        do_pass("v0_filt", 12'hFFF, 12'h000, 12'h000, 8'd255, 8'd0, 8'd0, 12'h000, 4'b0001, 1'b0, 509, 0);
        do_pass("min_byp", 12'h000, 12'h000, 12'h000, 8'd255, 8'd255, 8'd255, 12'h800, 4'b0000, 1'b0, 0, -8168);
        do_pass("v3off_b", 12'h000, 12'h000, 12'hFFF, 8'd0, 8'd0, 8'd255, 12'h000, 4'b0000, 1'b1, 0, 0);
        do_pass("v3off_f", 12'h000, 12'h000, 12'hFFF, 8'd0, 8'd0, 8'd255, 12'h000, 4'b0100, 1'b1, 509, 0);
        do_pass("ext_floor", 12'h123, 12'h456, 12'h789, 8'd0, 8'd0, 8'd0, 12'hFFD, 4'b1000, 1'b0, -1, 0);

        set_in(12'hFFF, 12'h000, 12'h000, 8'd255, 8'd0, 8'd0, 12'h000, 4'b0001, 1'b0);
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        set_in(12'h000, 12'hABC, 12'h321, 8'd99, 8'd200, 8'd17, 12'h7FF, 4'b0110, 1'b1);
        tick();
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        np = 0;
        for (int i = 3; i <= 7; i++) begin
            tick();
            if (valid) np++;
            if (i == 5) begin
                chk("ovr_valid_n5", int'(valid), 1);
                chk("ovr_filt_in", $signed(filt_in), 509);
                chk("ovr_bypass", $signed(bypass), 0);
            end
        end
        chk("ovr_pulses", np, 1);
        chk("ovr_flag", int'(overrun), 1);
        tick();
        tick();
        chk("ovr_sticky", int'(overrun), 1);

        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        np = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid) np++;
        end
        chk("abort_pulses", np, 0);
        chk("abort_filt_in", $signed(filt_in), 0);
        chk("abort_bypass", $signed(bypass), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_overrun", int'(overrun), 0);
        do_pass("after_abort", 12'hFFF, 12'h000, 12'h000, 8'd255, 8'd0, 8'd0, 12'h000, 4'b0001, 1'b0, 509, 0);

        reset = 1'b1;
        sample_stb = 1'b1;
        tick();
        reset = 1'b0;
        sample_stb = 1'b0;
        tick();
        chk("stb_in_reset_busy", int'(busy), 0);

        gap = 6;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++) begin
                wave[k] = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 12'hFFF : 12'h000)
                                                       : 12'($urandom_range(0, 4095));
                env[k] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            end
            ext_in = 12'($urandom_range(0, 4095));
            filt = 4'($urandom_range(0, 15));
            voice3off = 1'($urandom_range(0, 1));
            reset = $urandom_range(0, 399) == 0;
            sample_stb = gap >= 6 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
            gap = sample_stb ? 0 : gap + 1;
            tick();
        end
        sample_stb = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sid_voice_mixer.md
Name: sid_voice_mixer

Overview:
- Upstream stage of the SID filter: combines the three voice waveforms, scaled by their envelopes, plus the external audio input into two sums once per audio sample.
- The filter sum feeds the filter's 12-bit input. The bypass sum goes to the output stage alongside the filter output.
- One shared multiplier is time-multiplexed over the three voices by a small sequencer. All inputs are snapshotted on the sample strobe.

Parameters:
- WAVE_W, 12, width of the unsigned voice waveform inputs.
- ENV_W, 8, width of the unsigned envelope inputs.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sample_stb  in  1  one-cycle pulse; starts one mix pass
- wave0, wave1, wave2  in  WAVE_W  unsigned voice waveforms (0..4095)
- env0, env1, env2  in  ENV_W  unsigned envelope levels (0..255)
- ext_in  in  12  signed external audio input
- filt  in  4  routing: bits 0-2 route voice0-2 to the filter, bit 3 routes ext_in; a 0 bit sends that source to bypass
- voice3off  in  1  mutes voice2 in bypass only
- busy  out  1  high while a pass is in progress
- filt_in  out  12  signed filter-path sum (to filter input)
- bypass  out  14  signed unfiltered-path sum
- valid  out  1  one-cycle pulse when filt_in and bypass update
- overrun  out  1  sticky; set when sample_stb arrives while busy

Behaviour:
- Reset: state IDLE; filt_in=0, bypass=0, valid=0, busy=0, overrun=0, both accumulators 0. Reset mid-pass aborts the pass with no valid pulse.
- States: IDLE -> S_V0 -> S_V1 -> S_V2 -> S_EXT -> S_OUT -> IDLE.
- IDLE: when sample_stb=1 at edge N, register all inputs into snapshot registers, clear both accumulators, and enter S_V0 at N+1.
- busy=1 in S_V0 through S_OUT.
- S_Vk, one cycle each:
  - centred = wave_k - 2048, formed as a signed 12-bit value (invert the MSB).
  - term = (centred * env_k) >>> 8, using an arithmetic, flooring shift. Range is -2040..+2039.
  - If filt[k]=1, add term to acc_f; otherwise add it to acc_b.
  - Exception: when k=2, filt[2]=0 and voice3off=1, add nothing.
- S_EXT: add ext_in (sign-extended, no scaling) to acc_f if filt[3]=1, else to acc_b.
- S_OUT: filt_in <= acc_f >>> 2 (floor); bypass <= acc_b; valid=1 for this cycle only, so valid is high during cycle N+5.
- Latency: strobe sampled at edge N -> valid during cycle N+5. Minimum strobe spacing is 6 cycles.
- Accumulators are 14-bit signed. Worst case |sum| = 3*2040 + 2048 = 8168, so no overflow and no saturation logic is needed. filt_in always fits in 12 bits.
- Outputs hold their value between valid pulses.
- sample_stb while busy (S_V0..S_OUT): ignored, overrun <= 1. The current pass is unaffected. overrun clears only on reset.
- A strobe in the same cycle as reset is ignored.
- Input changes after the snapshot edge have no effect on the current pass.

Decomposition:
- Shared sid package holds: the state enum (IDLE, S_V0, S_V1, S_V2, S_EXT, S_OUT), the WAVE_CENTRE=2048 constant, and the ENV_SHIFT=8 constant.
- One sub-module is natural: sid_env_scale, the combinational centre-and-multiply-and-shift of one wave/env pair. It is instantiated once and fed through a snapshot mux.

Test Plan:
- wave0=4095, env0=255, env1=env2=0, ext_in=0, filt=4'b0001, strobe at N -> valid at N+5 only; filt_in=509, bypass=0, busy=0 at N+6.
- wave0..2=0, env0..2=255, ext_in=12'h800 (-2048), filt=4'b0000 -> bypass=-8168, filt_in=0.
- wave2=4095, env2=255, others env 0, voice3off=1, filt=0000 -> bypass=0. Same stimulus with filt=4'b0100 -> filt_in=509, bypass=0.
- ext_in=-3, filt=4'b1000, all env 0 -> filt_in=-1 (flooring shift), bypass=0.
- Strobe at N and N+2, with inputs changed at N+1 -> exactly one valid at N+5 with N-snapshot results; overrun=1 and stays set.
- Reset asserted at N+3 of a pass -> no valid pulse, outputs 0, busy 0; the next strobe completes normally 5 cycles later.
